// File: rtl/call_ret_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | call_ret_ctrl: turns CALL/RET/FLUSH commands into stack push/pop strobes |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module call_ret_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_pc,
  input  logic [31:0] cmd_target,
  output logic        rsp_valid,
  output logic [31:0] next_pc,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        stk_enable,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [31:0] stk_data_in,
  input  logic [31:0] stk_data_out,
  input  logic        stk_empty,
  input  logic [7:0]  stk_sp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_RET   = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVF   = 2'b01;
  localparam logic [1:0] FC_UNF   = 2'b10;
  localparam logic [7:0] FULL_SP  = 8'(DEPTH);

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc;
  logic        accept;
  logic        stk_full;
  logic        exec_push;
  logic        exec_pop;
  logic        flush_pop;

  assign accept   = cmd_valid && cmd_ready;
  assign stk_full = (stk_sp == FULL_SP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CALL:  state_nxt = stk_full  ? RESP : EXEC;
            OP_RET:   state_nxt = stk_empty ? RESP : EXEC;
            OP_FLUSH: state_nxt = FLUSH;
            default:  state_nxt = RESP;
          endcase
        end
      end
      EXEC:    state_nxt = RESP;
      FLUSH:   if (stk_empty) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from state only, so the async reset drops them at once.
  always_comb begin
    exec_push   = (state == EXEC) && (op_q == OP_CALL);
    exec_pop    = (state == EXEC) && (op_q == OP_RET);
    flush_pop   = (state == FLUSH) && !stk_empty;
    cmd_ready   = rst && (state == IDLE);
    rsp_valid   = (state == RESP);
    stk_push    = exec_push;
    stk_pop     = exec_pop || flush_pop;
    stk_enable  = exec_push || exec_pop || flush_pop;
    stk_data_in = exec_push ? (pc_q + 32'd4) : 32'd0;
  end

  // Successful CALL/RET park their result in pend_pc so the visible response
  // registers keep the previous response until this one is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 2'b00;
      pc_q       <= 32'd0;
      pend_pc    <= 32'd0;
      next_pc    <= 32'd0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
        pc_q <= cmd_pc;
        case (cmd_op)
          OP_CALL: begin
            if (stk_full) begin
              next_pc    <= cmd_pc + 32'd4;
              fault      <= 1'b1;
              fault_code <= FC_OVF;
            end else begin
              pend_pc <= cmd_target;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              next_pc    <= 32'd0;
              fault      <= 1'b1;
              fault_code <= FC_UNF;
            end else begin
              pend_pc <= stk_data_out;
            end
          end
          OP_FLUSH: ;
          default: begin
            next_pc    <= cmd_pc + 32'd4;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        endcase
      end
      if (state == EXEC) begin
        next_pc    <= pend_pc;
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end
      if ((state == FLUSH) && stk_empty) begin
        next_pc    <= pc_q + 32'd4;
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_call_ret_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_call_ret_ctrl: directed scoreboard bench with a behavioural stack     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_call_ret_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_pc = 32'd0;
  logic [31:0] cmd_target = 32'd0;
  logic        rsp_valid;
  logic [31:0] next_pc;
  logic        fault;
  logic [1:0]  fault_code;
  logic        stk_enable, stk_push, stk_pop;
  logic [31:0] stk_data_in, stk_data_out;
  logic        stk_empty;
  logic [7:0]  stk_sp;

  typedef struct packed {
    logic [31:0] pc;
    logic        flt;
    logic [1:0]  code;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] ra_q[$];
  int          checks = 0;
  int          errors = 0;
  int          push_cnt = 0;
  int          pop_cnt = 0;
  logic [31:0] last_push_data = 32'd0;

  always #5 clk = ~clk;

  call_ret_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pc(cmd_pc), .cmd_target(cmd_target),
    .rsp_valid(rsp_valid), .next_pc(next_pc), .fault(fault), .fault_code(fault_code),
    .stk_enable(stk_enable), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_empty(stk_empty), .stk_sp(stk_sp)
  );

  // Behavioural stack, reset from the same line as the controller.
  logic [31:0] mem [0:DEPTH-1];
  logic [7:0]  sp;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sp <= 8'd0;
    else if (stk_enable) begin
      if (stk_push && sp < 8'(DEPTH)) begin
        mem[sp[5:0]] <= stk_data_in;
        sp <= sp + 8'd1;
      end else if (stk_pop && sp != 8'd0) begin
        sp <= sp - 8'd1;
      end
    end
  end
  assign stk_sp       = sp;
  assign stk_empty    = (sp == 8'd0);
  assign stk_data_out = (sp == 8'd0) ? 32'd0 : mem[6'(int'(sp) - 1)];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response scoreboard and strobe monitor.
  always @(negedge clk) begin
    if (rst) begin
      chk("push_pop_exclusive", 32'(stk_push && stk_pop), 32'd0);
      if (stk_enable && stk_push) begin
        push_cnt++;
        last_push_data = stk_data_in;
      end
      if (stk_enable && stk_pop) pop_cnt++;
      if (rsp_valid) begin
        chk("rsp_strobes_idle", {29'd0, stk_enable, stk_push, stk_pop}, 32'd0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_next_pc", next_pc, e.pc);
          chk("rsp_fault", 32'(fault), 32'(e.flt));
          chk("rsp_fault_code", 32'(fault_code), 32'(e.code));
        end
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                        input rsp_t exp, output int lat);
    int w;
    lat = 0;
    sb.push_back(exp);
    @(negedge clk);
    cmd_op = op; cmd_pc = pc; cmd_target = tgt; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  // Reference model: shadow return-address stack decides the expected response.
  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       output int lat);
    rsp_t e;
    case (op)
      2'b01: begin
        if (ra_q.size() == DEPTH) e = '{pc + 32'd4, 1'b1, 2'b01};
        else begin ra_q.push_back(pc + 32'd4); e = '{tgt, 1'b0, 2'b00}; end
      end
      2'b10: begin
        if (ra_q.size() == 0) e = '{32'd0, 1'b1, 2'b10};
        else e = '{ra_q.pop_back(), 1'b0, 2'b00};
      end
      2'b11: begin ra_q.delete(); e = '{pc + 32'd4, 1'b0, 2'b00}; end
      default: e = '{pc + 32'd4, 1'b0, 2'b00};
    endcase
    do_cmd(op, pc, tgt, e, lat);
  endtask

  initial begin
    int lat, p0, q0;
    // Reset held for three cycles
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_next_pc", next_pc, 32'd0);
    chk("reset_fault", {29'd0, fault, fault_code}, 32'd0);
    chk("reset_strobes", {29'd0, stk_enable, stk_push, stk_pop}, 32'd0);
    chk("reset_data_in", stk_data_in, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_sp", 32'(stk_sp), 32'd0);

    // CALL/RET pair
    p0 = push_cnt; q0 = pop_cnt;
    issue(2'b01, 32'h100, 32'h400, lat);
    chk("call_latency", lat, 2);
    chk("call_push_data", last_push_data, 32'h104);
    chk("call_push_count", push_cnt - p0, 1);
    chk("call_sp", 32'(stk_sp), 32'd1);
    issue(2'b10, 32'h400, 32'h0, lat);
    chk("ret_latency", lat, 2);
    chk("ret_pop_count", pop_cnt - q0, 1);
    chk("ret_sp", 32'(stk_sp), 32'd0);

    // Nested calls
    issue(2'b01, 32'h10, 32'h1000, lat);
    issue(2'b01, 32'h20, 32'h2000, lat);
    issue(2'b01, 32'h30, 32'h3000, lat);
    chk("nested_sp", 32'(stk_sp), 32'd3);
    repeat (3) issue(2'b10, 32'h0, 32'h0, lat);
    chk("nested_sp_after", 32'(stk_sp), 32'd0);

    // Fill to capacity, then overflow
    for (int i = 0; i < DEPTH; i++) issue(2'b01, 32'h1000 + 32'(i * 8), 32'h8000 + 32'(i), lat);
    chk("full_sp", 32'(stk_sp), 32'd64);
    p0 = push_cnt;
    issue(2'b01, 32'h5000, 32'h6000, lat);
    chk("ovf_latency", lat, 1);
    chk("ovf_no_push", push_cnt - p0, 0);
    chk("ovf_sp", 32'(stk_sp), 32'd64);

    // Drain everything, then underflow
    issue(2'b11, 32'h700, 32'h0, lat);
    chk("flush64_latency", lat, 66);
    chk("flush64_sp", 32'(stk_sp), 32'd0);
    q0 = pop_cnt;
    issue(2'b10, 32'h900, 32'h0, lat);
    chk("unf_latency", lat, 1);
    chk("unf_no_pop", pop_cnt - q0, 0);

    // NOP clears the fault
    issue(2'b00, 32'h300, 32'h0, lat);
    chk("nop_latency", lat, 1);

    // FLUSH of five entries
    for (int i = 0; i < 5; i++) issue(2'b01, 32'h40 + 32'(i * 4), 32'hA00 + 32'(i), lat);
    q0 = pop_cnt;
    issue(2'b11, 32'hB00, 32'h0, lat);
    chk("flush5_pops", pop_cnt - q0, 5);
    chk("flush5_latency", lat, 7);
    chk("flush5_sp", 32'(stk_sp), 32'd0);

    // Reset during the second pop of a FLUSH
    for (int i = 0; i < 3; i++) issue(2'b01, 32'hC0 + 32'(i * 4), 32'hD00 + 32'(i), lat);
    @(negedge clk);
    cmd_op = 2'b11; cmd_pc = 32'hE00; cmd_valid = 1'b1;
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pop1", 32'(stk_pop), 32'd1);
    @(negedge clk);
    chk("midrst_pop2", 32'(stk_pop), 32'd1);
    chk("midrst_sp_before", 32'(stk_sp), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("midrst_strobes", {29'd0, stk_enable, stk_push, stk_pop}, 32'd0);
    chk("midrst_ready_low", 32'(cmd_ready), 32'd0);
    chk("midrst_sp", 32'(stk_sp), 32'd0);
    chk("midrst_outputs", {next_pc[29:0], fault, rsp_valid}, 32'd0);
    ra_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_idle", 32'(cmd_ready), 32'd1);
    issue(2'b01, 32'h200, 32'h800, lat);
    chk("after_rst_push", last_push_data, 32'h204);
    chk("after_rst_sp", 32'(stk_sp), 32'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
